// File: rtl/io_ctrl_regs.sv
// io_ctrl_regs
//   Control/status register block on SPI chip-select slot 1. Decodes
//   fetch (read) and load (write) strobes against a 5-bit register index.
//   It drives the LEDs, the PMOD outputs, the mixer controls and the RF
//   switch/LNA-shutdown pins. It also reports the push-button and the
//   config straps.
//
// Ports
//   i_sys_clk        system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_ioc[4:0]       register index of current command
//   i_data_in[7:0]   write data, qualified by i_load_cmd
//   o_data_out[7:0]  registered read data, held between fetches
//   i_cs             block select, gates both strobes
//   i_fetch_cmd      one-cycle read strobe
//   i_load_cmd       one-cycle write strobe
//   i_button         asynchronous push-button
//   i_config[3:0]    asynchronous config straps
//   o_led0/o_led1    LEDs
//   o_pmod[7:0]      PMOD output value
//   o_mixer_en/fm    mixer enable / FM select
//   o_rx_h_tx_l(_b)  RX/TX switch and complement
//   o_tr_vc1(_b)     filter-path switch 1 and complement
//   o_tr_vc2         filter-path switch 2
//   o_shdn_rx_lna    RX LNA shutdown, high = off
//   o_shdn_tx_lna    TX LNA shutdown, high = off
module io_ctrl_regs #(
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic       i_sys_clk,
  input  logic       i_reset,
  input  logic [4:0] i_ioc,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_cs,
  input  logic       i_fetch_cmd,
  input  logic       i_load_cmd,
  input  logic       i_button,
  input  logic [3:0] i_config,
  output logic       o_led0,
  output logic       o_led1,
  output logic [7:0] o_pmod,
  output logic       o_mixer_en,
  output logic       o_mixer_fm,
  output logic       o_rx_h_tx_l,
  output logic       o_rx_h_tx_l_b,
  output logic       o_tr_vc1,
  output logic       o_tr_vc1_b,
  output logic       o_tr_vc2,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna
);

  typedef enum logic [4:0] {
    REG_VERSION = 5'h00,
    REG_LED     = 5'h01,
    REG_STATUS  = 5'h02,
    REG_PMOD    = 5'h03,
    REG_RF_MODE = 5'h04,
    REG_MIXER   = 5'h05
  } reg_idx_e;

  typedef enum logic [2:0] {
    RF_LOW_POWER  = 3'd0,
    RF_BYPASS     = 3'd1,
    RF_RX_LOWPASS = 3'd2,
    RF_RX_HIPASS  = 3'd3,
    RF_TX_LOWPASS = 3'd4,
    RF_TX_HIPASS  = 3'd5
  } rf_mode_e;

  logic [1:0] led_q;
  logic [7:0] pmod_q;
  logic [2:0] rf_mode_q;
  logic [1:0] mixer_q;
  logic [4:0] in_meta_q;
  logic [4:0] in_sync_q;
  logic [7:0] rd_data;
  logic       rd_en;
  logic       wr_en;

  assign rd_en = i_cs & i_fetch_cmd;
  assign wr_en = i_cs & i_load_cmd;

  // Read mux works from the current register contents. A load in the same
  // cycle therefore reads back the value from before the write.
  always_comb begin
    rd_data = '0;
    case (i_ioc)
      REG_VERSION: rd_data = VERSION;
      REG_LED:     rd_data = {6'b0, led_q};
      REG_STATUS:  rd_data = {3'b0, in_sync_q};
      REG_PMOD:    rd_data = pmod_q;
      REG_RF_MODE: rd_data = {5'b0, rf_mode_q};
      REG_MIXER:   rd_data = {6'b0, mixer_q};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      led_q      <= '0;
      pmod_q     <= '0;
      rf_mode_q  <= '0;
      mixer_q    <= '0;
      in_meta_q  <= '0;
      in_sync_q  <= '0;
      o_data_out <= '0;
    end else begin
      in_meta_q <= {i_button, i_config};
      in_sync_q <= in_meta_q;
      if (rd_en) begin
        o_data_out <= rd_data;
      end
      if (wr_en) begin
        case (i_ioc)
          REG_LED:     led_q     <= i_data_in[1:0];
          REG_PMOD:    pmod_q    <= i_data_in;
          REG_RF_MODE: rf_mode_q <= i_data_in[2:0];
          REG_MIXER:   mixer_q   <= i_data_in[1:0];
          default:     ;
        endcase
      end
    end
  end

  assign o_led0     = led_q[0];
  assign o_led1     = led_q[1];
  assign o_pmod     = pmod_q;
  assign o_mixer_en = mixer_q[0];
  assign o_mixer_fm = mixer_q[1];

  // RF pins decode from the mode register alone. Each pin changes at most
  // once per register update. Modes 6 and 7 are kept for readback, but they
  // fall back to the low-power pattern.
  always_comb begin
    o_rx_h_tx_l   = 1'b1;
    o_tr_vc1      = 1'b1;
    o_tr_vc2      = 1'b1;
    o_shdn_rx_lna = 1'b1;
    o_shdn_tx_lna = 1'b1;
    case (rf_mode_q)
      RF_BYPASS: begin
        o_tr_vc1 = 1'b0;
        o_tr_vc2 = 1'b0;
      end
      RF_RX_LOWPASS: begin
        o_tr_vc2      = 1'b0;
        o_shdn_rx_lna = 1'b0;
      end
      RF_RX_HIPASS: begin
        o_tr_vc1      = 1'b0;
        o_shdn_rx_lna = 1'b0;
      end
      RF_TX_LOWPASS: begin
        o_rx_h_tx_l   = 1'b0;
        o_tr_vc1      = 1'b0;
        o_shdn_tx_lna = 1'b0;
      end
      RF_TX_HIPASS: begin
        o_rx_h_tx_l   = 1'b0;
        o_tr_vc2      = 1'b0;
        o_shdn_tx_lna = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_rx_h_tx_l_b = ~o_rx_h_tx_l;
  assign o_tr_vc1_b    = ~o_tr_vc1;

endmodule

// File: tb/tb_io_ctrl_regs.sv
// tb_io_ctrl_regs
//   Directed and random stimulus for io_ctrl_regs. A register-array reference
//   model and an RF pattern table supply every expected value.
module tb_io_ctrl_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ioc = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       cs = 1'b0;
  logic       fetch = 1'b0;
  logic       load = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] cfg = '0;
  logic       led0, led1, mix_en, mix_fm;
  logic [7:0] pmod;
  logic       rxtx, rxtx_b, vc1, vc1_b, vc2, shrx, shtx;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_reg [0:5];
  logic [7:0] m_mask [0:5] = '{8'h00, 8'h03, 8'h00, 8'hFF, 8'h07, 8'h03};
  logic [4:0] m_hist [0:1];   // input sampled 1 and 2 edges ago
  logic [7:0] m_dout;
  // {rx_h_tx_l, vc1, vc2, shdn_rx, shdn_tx} per mode
  logic [4:0] rf_tab [0:7] = '{5'b11111, 5'b10011, 5'b11001, 5'b10101,
                               5'b00110, 5'b01010, 5'b11111, 5'b11111};

  io_ctrl_regs #(.VERSION(8'h01)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_ioc(ioc), .i_data_in(din),
    .o_data_out(dout), .i_cs(cs), .i_fetch_cmd(fetch), .i_load_cmd(load),
    .i_button(btn), .i_config(cfg), .o_led0(led0), .o_led1(led1),
    .o_pmod(pmod), .o_mixer_en(mix_en), .o_mixer_fm(mix_fm),
    .o_rx_h_tx_l(rxtx), .o_rx_h_tx_l_b(rxtx_b), .o_tr_vc1(vc1),
    .o_tr_vc1_b(vc1_b), .o_tr_vc2(vc2), .o_shdn_rx_lna(shrx),
    .o_shdn_tx_lna(shtx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 8'h01;
    if (a == 5'd2) return {3'b0, m_hist[1]};
    if (a < 5'd6)  return m_reg[a];
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] p;
    p = rf_tab[m_reg[4][2:0]];
    chk("dout", dout, m_dout);
    chk("led0", {7'b0, led0}, {7'b0, m_reg[1][0]});
    chk("led1", {7'b0, led1}, {7'b0, m_reg[1][1]});
    chk("pmod", pmod, m_reg[3]);
    chk("mixer_en", {7'b0, mix_en}, {7'b0, m_reg[5][0]});
    chk("mixer_fm", {7'b0, mix_fm}, {7'b0, m_reg[5][1]});
    chk("rx_h_tx_l", {7'b0, rxtx}, {7'b0, p[4]});
    chk("rx_h_tx_l_b", {7'b0, rxtx_b}, {7'b0, ~p[4]});
    chk("tr_vc1", {7'b0, vc1}, {7'b0, p[3]});
    chk("tr_vc1_b", {7'b0, vc1_b}, {7'b0, ~p[3]});
    chk("tr_vc2", {7'b0, vc2}, {7'b0, p[2]});
    chk("shdn_rx", {7'b0, shrx}, {7'b0, p[1]});
    chk("shdn_tx", {7'b0, shtx}, {7'b0, p[0]});
  endtask

  // Drive one command, let it be sampled, advance the model, then check.
  task automatic cycle(input logic r, input logic c, input logic [4:0] a,
                       input logic [7:0] d, input logic f, input logic l);
    logic [7:0] rd;
    rst = r; cs = c; ioc = a; din = d; fetch = f; load = l;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
      m_hist[0] = '0; m_hist[1] = '0;
      m_dout = 8'h00;
    end else begin
      rd = model_read(a);
      if (c && f) m_dout = rd;
      if (c && l && a < 5'd6) m_reg[a] = d & m_mask[a];
      m_hist[1] = m_hist[0];
      m_hist[0] = {btn, cfg};
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] a;
    int k;
    for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
    m_hist[0] = '0; m_hist[1] = '0;
    m_dout = 8'h00;

    // Reset for two cycles
    cycle(1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    chk("reset_dout", dout, 8'h00);
    chk("reset_rxtx", {7'b0, rxtx}, 8'h01);
    chk("reset_shrx", {7'b0, shrx}, 8'h01);

    // Version and unmapped reads, deselected fetch
    cycle(1'b0, 1'b1, 5'h00, 8'h00, 1'b1, 1'b0);
    chk("version", dout, 8'h01);
    cycle(1'b0, 1'b1, 5'h1F, 8'h00, 1'b1, 1'b0);
    chk("unmapped", dout, 8'h00);
    cycle(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
    chk("cs_low_hold", dout, 8'h00);

    // Every RF mode
    for (int m = 0; m < 8; m++) begin
      cycle(1'b0, 1'b1, 5'h04, 8'(m) | 8'hF8, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b1, 5'h04, 8'h00, 1'b1, 1'b0);
    chk("rf_readback7", dout, 8'h07);
    cycle(1'b0, 1'b1, 5'h04, 8'h04, 1'b0, 1'b1);
    chk("tx_lowpass_pins", {3'b0, rxtx, vc1, vc2, shrx, shtx}, 8'b00110);

    // Masking
    cycle(1'b0, 1'b1, 5'h01, 8'hFF, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 5'h01, 8'h00, 1'b1, 1'b0);
    chk("led_readback", dout, 8'h03);
    cycle(1'b0, 1'b1, 5'h03, 8'hA5, 1'b0, 1'b1);
    chk("pmod_a5", pmod, 8'hA5);
    cycle(1'b0, 1'b1, 5'h05, 8'h02, 1'b0, 1'b1);
    chk("mixer_fm_only", {6'b0, mix_fm, mix_en}, 8'h02);

    // Synchronised inputs
    btn = 1'b1; cfg = 4'hC;
    idle();
    idle();
    cycle(1'b0, 1'b1, 5'h02, 8'h00, 1'b1, 1'b0);
    chk("status_1c", dout, 8'h1C);

    // Same-cycle fetch and load
    cycle(1'b0, 1'b1, 5'h03, 8'h3C, 1'b1, 1'b1);
    chk("collide_read", dout, 8'hA5);
    chk("collide_write", pmod, 8'h3C);

    // Reset wins over a load
    cycle(1'b1, 1'b1, 5'h01, 8'h03, 1'b0, 1'b1);
    chk("reset_prio_leds", {6'b0, led1, led0}, 8'h00);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      btn = 1'($urandom_range(0, 1));
      cfg = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 9);
      if (k < 7) a = 5'(k);
      else a = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), a,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
